// File: rtl/prog_mem_pkg.sv
// Purpose: shared types and constants for the program memory block.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: loader/fetch FSM state encoding, the NOP word used to pad
// short program images, and small field-extraction helpers.
package prog_mem_pkg;

    // Controller states. IDLE is the reset state. RUN is the only state
    // in which the image is complete and fetchable.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_FILL = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    // Widest program word supported by the NOP constant below. Users slice
    // the low DATA_W bits, so the constant works for any DATA_W up to this.
    localparam int NOP_MAX_W = 256;

    // All-zero word: the NOP opcode with a zero immediate. Written into
    // every address past the end of a short program image.
    localparam logic [NOP_MAX_W-1:0] NOP_WORD = '0;

    // Number of words in a program image of the given address width.
    function automatic int prog_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage : prog_mem_pkg

// File: rtl/prog_mem_ram.sv
// Purpose: program word storage, one write port and one registered read port.
// Latency: read data appears one cycle after rd_en; holds while rd_en is low.
// Backpressure: none; both ports accept every cycle they are enabled.
//
// Ports:
//   clk                      rising-edge clock
//   wr_en / wr_addr / wr_data  write port
//   rd_en / rd_addr          read request; rd_data registered, held when idle
//
// The array and the read register are deliberately not reset so that a
// program image survives a controller reset.
module prog_mem_ram
    import prog_mem_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int DEPTH = prog_depth(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule : prog_mem_ram

// File: rtl/prog_mem.sv
// Purpose: loadable program memory; streams in an image, zero-pads short
//          images, then serves single-cycle registered instruction fetches.
// Latency: fetch 1 cycle (rd_req -> rd_valid); ld_done 1 cycle after the
//          final write of the image.
// Backpressure: ld_ready is high only while loading; fetches are only
//          honoured once the image is complete (ready high), never stalled.
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   ld_start                        begin a new load at address 0 (IDLE/RUN)
//   ld_valid / ld_ready / ld_data   loader word handshake, opcode in MSBs
//   ld_last                         final loader word; rest is NOP-filled
//   ld_done                         one-cycle pulse, full image written
//   rd_req / rd_addr                fetch request
//   rd_valid / rd_data              fetched word, held when rd_valid low
//   rd_opcode / rd_imdata           opcode and immediate fields of rd_data
//   ready                           image complete, fetches accepted
module prog_mem
    import prog_mem_pkg::*;
#(
    parameter int ADDR_W = 4,
    parameter int OP_W   = 4,
    parameter int IM_W   = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ld_start,
    input  logic                   ld_valid,
    input  logic [OP_W+IM_W-1:0]   ld_data,
    input  logic                   ld_last,
    output logic                   ld_ready,
    output logic                   ld_done,
    input  logic                   rd_req,
    input  logic [ADDR_W-1:0]      rd_addr,
    output logic                   rd_valid,
    output logic [OP_W+IM_W-1:0]   rd_data,
    output logic [OP_W-1:0]        rd_opcode,
    output logic [IM_W-1:0]        rd_imdata,
    output logic                   ready
);

    localparam int DATA_W = OP_W + IM_W;
    localparam logic [ADDR_W-1:0] PTR_LAST = '1;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic              rd_seen;

    logic              ld_fire;
    logic              fill_fire;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;
    logic              wr_last;
    logic              rd_fire;
    logic [DATA_W-1:0] ram_q;

    // Write side: loader words in LOAD, NOP padding every cycle in FILL.
    assign ld_fire   = (state == ST_LOAD) && ld_valid;
    assign fill_fire = (state == ST_FILL);
    assign wr_en     = ld_fire || fill_fire;
    assign wr_data   = fill_fire ? NOP_WORD[DATA_W-1:0] : ld_data;
    assign wr_last   = wr_en && (ptr == PTR_LAST);

    // Fetches are only meaningful against a complete image.
    assign rd_fire   = rd_req && (state == ST_RUN);

    assign ld_ready  = (state == ST_LOAD);
    assign ready     = (state == ST_RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ptr      <= '0;
            ld_done  <= 1'b0;
            rd_valid <= 1'b0;
            rd_seen  <= 1'b0;
        end else begin
            ld_done  <= wr_last;
            rd_valid <= rd_fire;
            if (rd_fire) begin
                rd_seen <= 1'b1;
            end

            case (state)
                // A fetch arriving with ld_start in RUN is still serviced:
                // the RAM read happens this edge, before any new write.
                ST_IDLE, ST_RUN: begin
                    if (ld_start) begin
                        state <= ST_LOAD;
                        ptr   <= '0;
                    end
                end

                // The last address always completes the image, whatever
                // ld_last says, so the pointer can never wrap into a
                // second write of address 0.
                ST_LOAD: begin
                    if (ld_valid) begin
                        if (ptr == PTR_LAST) begin
                            state <= ST_RUN;
                            ptr   <= '0;
                        end else begin
                            ptr <= ptr + ADDR_W'(1);
                            if (ld_last) begin
                                state <= ST_FILL;
                            end
                        end
                    end
                end

                ST_FILL: begin
                    if (ptr == PTR_LAST) begin
                        state <= ST_RUN;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + ADDR_W'(1);
                    end
                end

                default: begin
                    state <= ST_IDLE;
                    ptr   <= '0;
                end
            endcase
        end
    end

    prog_mem_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (ptr),
        .wr_data (wr_data),
        .rd_en   (rd_fire),
        .rd_addr (rd_addr),
        .rd_data (ram_q)
    );

    // The RAM read register has no reset, so until the first fetch after
    // reset the output is forced to zero. Afterwards the RAM register holds
    // the last fetched word while rd_valid is low.
    assign rd_data   = rd_seen ? ram_q : '0;
    assign rd_opcode = rd_data[DATA_W-1:IM_W];
    assign rd_imdata = rd_data[IM_W-1:0];

endmodule : prog_mem

// File: tb/tb_prog_mem.sv
module tb_prog_mem;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic       rst_n;
    logic       ld_start, ld_valid, ld_last, ld_ready, ld_done;
    logic [7:0] ld_data;
    logic       rd_req, rd_valid, ready;
    logic [3:0] rd_addr;
    logic [7:0] rd_data;
    logic [3:0] rd_opcode, rd_imdata;

    // wide instance
    logic        w_ld_start, w_ld_valid, w_ld_last, w_ld_ready, w_ld_done;
    logic [15:0] w_ld_data;
    logic        w_rd_req, w_rd_valid, w_ready;
    logic [5:0]  w_rd_addr;
    logic [15:0] w_rd_data;
    logic [4:0]  w_rd_opcode;
    logic [10:0] w_rd_imdata;

    prog_mem dut (
        .clk(clk), .rst_n(rst_n),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .ld_done(ld_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid),
        .rd_data(rd_data), .rd_opcode(rd_opcode), .rd_imdata(rd_imdata),
        .ready(ready)
    );

    prog_mem #(.ADDR_W(6), .OP_W(5), .IM_W(11)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .ld_start(w_ld_start), .ld_valid(w_ld_valid), .ld_data(w_ld_data),
        .ld_last(w_ld_last), .ld_ready(w_ld_ready), .ld_done(w_ld_done),
        .rd_req(w_rd_req), .rd_addr(w_rd_addr), .rd_valid(w_rd_valid),
        .rd_data(w_rd_data), .rd_opcode(w_rd_opcode), .rd_imdata(w_rd_imdata),
        .ready(w_ready)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  img   [16];
    logic [7:0]  model [16];
    logic [15:0] w_img [64];
    logic [7:0]  sb_q   [$];
    logic [15:0] w_sb_q [$];
    int done_cnt = 0, done_cyc = 0, w_done_cnt = 0;
    int first_acc, fill_cnt;
    bit fill_rd = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h exp 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // scoreboards: pop expected word on every fetch response
    always @(negedge clk) begin
        if (ld_done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (rd_valid === 1'b1) begin
            if (sb_q.size() == 0) chk("rd_vld_unexp", rd_valid, 0);
            else begin
                logic [7:0] e;
                e = sb_q.pop_front();
                chk("rd_data", rd_data, e);
                chk("rd_opcode", rd_opcode, e[7:4]);
                chk("rd_imdata", rd_imdata, e[3:0]);
            end
        end
    end

    always @(negedge clk) begin
        if (w_ld_done === 1'b1) w_done_cnt++;
        if (w_rd_valid === 1'b1) begin
            if (w_sb_q.size() == 0) chk("w_rd_vld_unexp", w_rd_valid, 0);
            else begin
                logic [15:0] e;
                e = w_sb_q.pop_front();
                chk("w_rd_data", w_rd_data, e);
                chk("w_rd_opcode", w_rd_opcode, e[15:11]);
                chk("w_rd_imdata", w_rd_imdata, e[10:0]);
            end
        end
    end

    // svc: bench expects the DUT to be in RUN, so a response is due
    task automatic rd(input int a, input bit svc);
        rd_req  = 1'b1;
        rd_addr = a[3:0];
        if (svc) sb_q.push_back(model[a]);
        step();
        rd_req = 1'b0;
    endtask

    task automatic rd_all();
        for (int a = 0; a < 16; a++) rd(a, 1'b1);
        step();
    endtask

    task automatic do_load(input int n, input bit use_last, input bit rnd, input bit start);
        int idx = 0;
        int g = 0;
        int d0 = done_cnt;
        int pre;
        if (start) begin
            ld_start = 1'b1;
            step();
            ld_start = 1'b0;
        end
        first_acc = -1;
        while (idx < n && g < 2000) begin
            ld_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            ld_data  = img[idx];
            ld_last  = use_last && (idx == n - 1);
            chk("ld_rdy_load", ld_ready, 1);
            pre = cyc;
            step();
            g++;
            if (ld_valid) begin
                if (first_acc < 0) first_acc = pre;
                idx++;
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        fill_cnt = 0;
        g = 0;
        while (!ready && g < 100) begin
            if (!ld_ready) fill_cnt++;
            if (fill_rd) rd_req = 1'b1;
            step();
            g++;
            if (fill_rd) chk("rd_vld_fill", rd_valid, 0);
        end
        rd_req = 1'b0;
        chk("ready_run", ready, 1);
        chk("fill_len", fill_cnt, 16 - n);
        step();
        chk("done_cnt", done_cnt - d0, 1);
        if (!rnd) chk("done_lat", done_cyc - first_acc, 16);
        for (int i = 0; i < 16; i++) model[i] = (i < n) ? img[i] : 8'h00;
    endtask

    initial begin
        logic [7:0] base [16];
        base = '{8'h01, 8'h80, 8'h01, 8'h80, 8'h14, 8'h90, 8'h28, 8'h80,
                 8'h90, 8'h30, 8'h90, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        rst_n = 1'b0;
        ld_start = 0; ld_valid = 0; ld_last = 0; ld_data = 0; rd_req = 0; rd_addr = 0;
        w_ld_start = 0; w_ld_valid = 0; w_ld_last = 0; w_ld_data = 0; w_rd_req = 0; w_rd_addr = 0;
        step(); step();
        chk("rst_ready", ready, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_ld_done", ld_done, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        step();

        // fetch in IDLE is ignored
        rd(2, 1'b0);
        chk("rd_vld_idle", rd_valid, 0);

        // full 16-word image, continuous valid
        img = base;
        do_load(16, 1'b0, 1'b0, 1'b1);
        rd(4, 1'b1);
        chk("a4_opcode", rd_opcode, 4'h1);
        chk("a4_imdata", rd_imdata, 4'h4);
        step(); step(); step();
        chk("hold_vld", rd_valid, 0);
        chk("hold_data", rd_data, 8'h14);
        rd_all();

        // short image with ld_last, fetch attempts during FILL
        img[0] = 8'hA1; img[1] = 8'hB2; img[2] = 8'hC3;
        fill_rd = 1'b1;
        do_load(3, 1'b1, 1'b0, 1'b1);
        fill_rd = 1'b0;
        rd_all();

        // random valid gaps
        for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
        do_load(16, 1'b0, 1'b1, 1'b1);
        rd_all();

        // fetch together with ld_start in RUN: old word returned
        rd_req = 1'b1; rd_addr = 4'd5; ld_start = 1'b1;
        sb_q.push_back(model[5]);
        step();
        rd_req = 1'b0; ld_start = 1'b0;
        chk("ready_drop", ready, 0);
        chk("old_word", rd_data, model[5]);
        img = base;
        do_load(16, 1'b0, 1'b0, 1'b0);
        rd_all();

        // reset at pointer 7 of a load
        for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
        ld_start = 1'b1; step(); ld_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ld_valid = 1'b1; ld_data = img[i]; step();
        end
        ld_valid = 1'b0;
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("midld_ready", ready, 0);
        chk("midld_ld_ready", ld_ready, 0);
        rd(1, 1'b0);
        chk("midld_rd_vld", rd_valid, 0);
        do_load(16, 1'b0, 1'b0, 1'b1);
        rd_all();

        // reset in RUN, then reload of the same image
        rst_n = 1'b0; step(); rst_n = 1'b1;
        chk("runrst_ready", ready, 0);
        chk("runrst_rd_data", rd_data, 0);
        do_load(16, 1'b0, 1'b0, 1'b1);
        rd_all();

        // wide instance: 64-word load, field split at 63
        for (int i = 0; i < 64; i++) w_img[i] = 16'($urandom);
        w_img[63] = 16'hABCD;
        w_ld_start = 1'b1; step(); w_ld_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chk("w_ld_rdy", w_ld_ready, 1);
            w_ld_valid = 1'b1; w_ld_data = w_img[i]; step();
        end
        w_ld_valid = 1'b0;
        chk("w_ready", w_ready, 1);
        step();
        chk("w_done_cnt", w_done_cnt, 1);
        for (int k = 0; k < 4; k++) begin
            int a;
            a = (k < 2) ? k : 60 + k;
            w_rd_req = 1'b1; w_rd_addr = a[5:0];
            w_sb_q.push_back(w_img[a]);
            step();
            w_rd_req = 1'b0;
        end
        chk("w_a63_opcode", w_rd_opcode, 5'h15);
        chk("w_a63_imdata", w_rd_imdata, 11'h3CD);

        step(); step();
        chk("sb_drain", sb_q.size(), 0);
        chk("w_sb_drain", w_sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

endmodule : tb_prog_mem
